// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-requester round-robin arbiter and sequencer for a single-port RAM
module ram_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_req,
    input  logic                  a_wr,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_wr,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  ram_write_enb,
    output logic                  ram_read_enb,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    // Final WAIT count; WAIT is skipped entirely when RD_LATENCY is 1.
    localparam logic [1:0] CNT_LAST = 2'((RD_LATENCY > 1) ? (RD_LATENCY - 2) : 0);

    state_t                state, state_nxt;
    logic                  last_b, last_b_nxt;   // 1: last grant went to B
    logic                  win_b, win_b_nxt;     // 1: current transaction belongs to B
    logic [1:0]            cnt, cnt_nxt;
    logic                  pick_b, go_resp;
    logic                  a_gnt_nxt, b_gnt_nxt, a_rvalid_nxt, b_rvalid_nxt;
    logic                  we_nxt, re_nxt, busy_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [DATA_WIDTH-1:0] din_nxt, a_rdata_nxt, b_rdata_nxt;

    // Next state and next values of every registered output.
    always_comb begin
        state_nxt    = state;
        last_b_nxt   = last_b;
        win_b_nxt    = win_b;
        cnt_nxt      = cnt;
        addr_nxt     = ram_address;
        din_nxt      = ram_data_in;
        a_rdata_nxt  = a_rdata;
        b_rdata_nxt  = b_rdata;
        a_gnt_nxt    = 1'b0;
        b_gnt_nxt    = 1'b0;
        a_rvalid_nxt = 1'b0;
        b_rvalid_nxt = 1'b0;
        we_nxt       = 1'b0;
        re_nxt       = 1'b0;
        pick_b       = 1'b0;
        go_resp      = 1'b0;
        case (state)
            IDLE: begin
                if (a_req || b_req) begin
                    pick_b     = b_req && (!a_req || !last_b);
                    win_b_nxt  = pick_b;
                    last_b_nxt = pick_b;
                    addr_nxt   = pick_b ? b_addr : a_addr;
                    din_nxt    = pick_b ? b_wdata : a_wdata;
                    we_nxt     = pick_b ? b_wr : a_wr;
                    re_nxt     = pick_b ? !b_wr : !a_wr;
                    a_gnt_nxt  = !pick_b;
                    b_gnt_nxt  = pick_b;
                    state_nxt  = ISSUE;
                end
            end
            ISSUE: begin
                if (ram_write_enb) begin
                    state_nxt = IDLE;
                end else if (RD_LATENCY == 1) begin
                    go_resp = 1'b1;
                end else begin
                    state_nxt = WAIT;
                    cnt_nxt   = 2'd0;
                end
            end
            WAIT: begin
                if (cnt == CNT_LAST) begin
                    go_resp = 1'b1;
                end else begin
                    cnt_nxt = cnt + 2'd1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (go_resp) begin
            state_nxt = RESP;
            if (win_b) begin
                b_rdata_nxt  = ram_data_out;
                b_rvalid_nxt = 1'b1;
            end else begin
                a_rdata_nxt  = ram_data_out;
                a_rvalid_nxt = 1'b1;
            end
        end
        busy_nxt = (state_nxt != IDLE);
    end

    // State, arbitration history and all outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            last_b        <= 1'b1;
            win_b         <= 1'b0;
            cnt           <= 2'd0;
            a_gnt         <= 1'b0;
            b_gnt         <= 1'b0;
            a_rvalid      <= 1'b0;
            b_rvalid      <= 1'b0;
            a_rdata       <= '0;
            b_rdata       <= '0;
            ram_write_enb <= 1'b0;
            ram_read_enb  <= 1'b0;
            ram_address   <= '0;
            ram_data_in   <= '0;
            busy          <= 1'b0;
        end else begin
            state         <= state_nxt;
            last_b        <= last_b_nxt;
            win_b         <= win_b_nxt;
            cnt           <= cnt_nxt;
            a_gnt         <= a_gnt_nxt;
            b_gnt         <= b_gnt_nxt;
            a_rvalid      <= a_rvalid_nxt;
            b_rvalid      <= b_rvalid_nxt;
            a_rdata       <= a_rdata_nxt;
            b_rdata       <= b_rdata_nxt;
            ram_write_enb <= we_nxt;
            ram_read_enb  <= re_nxt;
            ram_address   <= addr_nxt;
            ram_data_in   <= din_nxt;
            busy          <= busy_nxt;
        end
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single-port RAM.
- Owns the RAM's `write_enb`, `read_enb`, `address` and `data_in`; captures `data_out`.
- Requesters A and B issue one read or write each through a req/gnt handshake; read data returns on a per-requester rvalid pulse.
- At most one transaction is in flight; the RAM is never driven by two requesters in the same cycle.

Parameters:
- DATA_WIDTH, 8, RAM word width.
- ADDR_WIDTH, 6, RAM address width (depth 2**ADDR_WIDTH).
- RD_LATENCY, 1, cycles from the `ram_read_enb` cycle until `ram_data_out` is valid; legal range 1..4.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- a_req  in  1  requester A transaction request; held until a_gnt.
- a_wr  in  1  A command: 1 = write, 0 = read.
- a_addr  in  ADDR_WIDTH  A address.
- a_wdata  in  DATA_WIDTH  A write data.
- a_gnt  out  1  one-cycle pulse: A's command is on the RAM this cycle.
- a_rvalid  out  1  one-cycle pulse: a_rdata holds A's read result.
- a_rdata  out  DATA_WIDTH  A read data; held until A's next read completes.
- b_req, b_wr, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same widths and meanings for requester B.
- ram_write_enb  out  1  RAM write enable.
- ram_read_enb  out  1  RAM read enable.
- ram_address  out  ADDR_WIDTH  RAM address.
- ram_data_in  out  DATA_WIDTH  RAM write data.
- ram_data_out  in  DATA_WIDTH  RAM read data.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any cycle):
  - all outputs go to 0 and `a_rdata`/`b_rdata` clear to 0;
  - FSM returns to IDLE; `last_grant` goes to B, so A has priority next;
  - any in-flight transaction is abandoned with no gnt and no rvalid.
- FSM states are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req inputs are sampled only in this state.
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, that requester wins.
  - If both are high, the requester not equal to `last_grant` wins.
  - The winner's wr/addr/wdata and identity are latched; `last_grant` is updated; next state is ISSUE.
- ISSUE (exactly 1 cycle):
  - `ram_address`/`ram_data_in` = latched values.
  - Write: `ram_write_enb` = 1. Read: `ram_read_enb` = 1.
  - Winner's gnt = 1.
  - Next state: IDLE for a write; WAIT for a read.
- WAIT: count RD_LATENCY-1 cycles (0 cycles when RD_LATENCY = 1, i.e. go straight to RESP). Both RAM enables are 0.
- RESP (1 cycle):
  - At the clock edge that enters RESP, `ram_data_out` is registered into the winner's rdata.
  - During RESP, the winner's rvalid = 1.
  - Next state: IDLE.
- Latency:
  - Write: req seen in IDLE at cycle N → gnt and `ram_write_enb` at N+1 → IDLE at N+2.
  - Read: gnt and `ram_read_enb` at N+1 → rvalid at N+1+RD_LATENCY → IDLE at N+2+RD_LATENCY.
- Throughput: one write per 2 cycles; one read per 2+RD_LATENCY cycles.
- Invariants:
  - `ram_write_enb` and `ram_read_enb` are never high together.
  - Both enables are 0 outside ISSUE.
  - gnt is never given to both requesters in the same cycle.
  - rvalid only follows a read gnt to the same requester.
- Handshake:
  - A requester holds req and its command stable until its gnt.
  - After gnt it may drop req, or keep req high with a new command; the new command is sampled at the next IDLE.
  - If req drops after being latched but before gnt, the latched command still executes (protocol violation; not checked).
- Fairness: under continuous contention from both, grants strictly alternate A, B, A, B…
- Addresses pass through unmodified; all 2**ADDR_WIDTH locations are reachable. No wrap or arithmetic is performed.
- The non-winning requester's rdata is never modified.

Test Plan:
- Reset: assert reset mid-cycle → all outputs 0, `busy` = 0, immediately (asynchronous); release; idle 5 cycles → `ram_write_enb`/`ram_read_enb` stay 0.
- A writes 0xA5 to address 0x10, then A reads 0x10 (RD_LATENCY = 1):
  - `ram_write_enb` high 1 cycle with address 0x10, data 0xA5;
  - `a_rvalid` pulses 1 cycle after the read's `a_gnt`, with `a_rdata` = 0xA5;
  - `b_rdata` stays 0.
- Both req high right after reset (A write 0x11 @0x01, B write 0x22 @0x02): A granted first, then B; RAM holds both values.
- Contention:
  - both hold req for 6 transactions → grant order A, B, A, B, A, B;
  - never two gnts in one cycle; enables never overlap.
- Reset mid-read: assert reset during WAIT (RD_LATENCY = 3) → no rvalid; FSM in IDLE; next simultaneous request grants A.
- B-only: back-to-back writes to address 63 (0x3F) with 0x01 then 0x02, then a read of 63 → `b_rdata` = 0x02; `a_gnt` never asserts.
